// File: rtl/alu_arbiter_if.sv
// Handshake and shared-ALU bundle for alu_arbiter.
// slave: arbiter side; master: requesters plus the shared ALU.
interface alu_arbiter_if;
  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [31:0] req0_data1_i;
  logic [31:0] req0_data2_i;
  logic [2:0]  req0_opcode_i;
  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [31:0] req1_data1_i;
  logic [31:0] req1_data2_i;
  logic [2:0]  req1_opcode_i;
  logic        resp0_valid_o;
  logic        resp0_ready_i;
  logic        resp1_valid_o;
  logic        resp1_ready_i;
  logic [31:0] resp_data_o;
  logic        resp_zero_o;
  logic [31:0] alu_data1_o;
  logic [31:0] alu_data2_o;
  logic [2:0]  alu_opcode_o;
  logic [31:0] alu_data_i;
  logic        alu_zero_i;
  logic        busy_o;

  modport slave (
    input  req0_valid_i, req0_data1_i,
    input  req0_data2_i, req0_opcode_i,
    input  req1_valid_i, req1_data1_i,
    input  req1_data2_i, req1_opcode_i,
    input  resp0_ready_i, resp1_ready_i,
    input  alu_data_i, alu_zero_i,
    output req0_ready_o, req1_ready_o,
    output resp0_valid_o, resp1_valid_o,
    output resp_data_o, resp_zero_o,
    output alu_data1_o, alu_data2_o,
    output alu_opcode_o, busy_o
  );

  modport master (
    output req0_valid_i, req0_data1_i,
    output req0_data2_i, req0_opcode_i,
    output req1_valid_i, req1_data1_i,
    output req1_data2_i, req1_opcode_i,
    output resp0_ready_i, resp1_ready_i,
    output alu_data_i, alu_zero_i,
    input  req0_ready_o, req1_ready_o,
    input  resp0_valid_o, resp1_valid_o,
    input  resp_data_o, resp_zero_o,
    input  alu_data1_o, alu_data2_o,
    input  alu_opcode_o, busy_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared ALU, one op in flight.
// Ports: clk_i, rst_i (sync, active-high), bus (alu_arbiter_if.slave).
// ALU_LAT: ALU settle cycles (1..8) before the result is captured.
// Macro ALU_ARB_ROUND_ROBIN_EN: round-robin ties, else req0 wins.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  cnt_q;
  logic [31:0] d1_q;
  logic [31:0] d2_q;
  logic [2:0]  op_q;
  logic [31:0] res_q;
  logic        zero_q;
  logic        gnt_q;
  logic        gnt;
  logic        tie1;
  logic        rdy0;
  logic        rdy1;
  logic        rv0;
  logic        rv1;
  logic        busy;
  logic        req_hs;
  logic        resp_hs;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Last-served pointer; reset to 1 so req0 wins the first tie.
  logic last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (resp_hs) begin
      last_q <= gnt_q;
    end
  end

  assign tie1 = ~last_q;
`else
  assign tie1 = 1'b0;
`endif

  assign gnt = bus.req1_valid_i &
               (~bus.req0_valid_i | tie1);

  assign req_hs  = (bus.req0_valid_i & rdy0) |
                   (bus.req1_valid_i & rdy1);
  assign resp_hs = (state_q == RESP) &
                   (gnt_q ? bus.resp1_ready_i
                          : bus.resp0_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_hs) state_d = EXEC;
      EXEC: if (cnt_q == 3'd0) state_d = RESP;
      RESP: if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is also held low while reset is asserted.
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    rv0  = 1'b0;
    rv1  = 1'b0;
    busy = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        rdy0 = ~rst_i & ~gnt;
        rdy1 = ~rst_i & gnt;
      end
      EXEC: busy = 1'b1;
      RESP: begin
        rv0 = ~gnt_q;
        rv1 = gnt_q;
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= 3'd0;
      d1_q   <= '0;
      d2_q   <= '0;
      op_q   <= '0;
      gnt_q  <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      if (state_q == IDLE && req_hs) begin
        cnt_q <= CNT_INIT;
        gnt_q <= gnt;
        d1_q  <= gnt ? bus.req1_data1_i
                     : bus.req0_data1_i;
        d2_q  <= gnt ? bus.req1_data2_i
                     : bus.req0_data2_i;
        op_q  <= gnt ? bus.req1_opcode_i
                     : bus.req0_opcode_i;
      end
      if (state_q == EXEC) begin
        if (cnt_q == 3'd0) begin
          res_q  <= bus.alu_data_i;
          zero_q <= bus.alu_zero_i;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
      end
    end
  end

  assign bus.req0_ready_o  = rdy0;
  assign bus.req1_ready_o  = rdy1;
  assign bus.resp0_valid_o = rv0;
  assign bus.resp1_valid_o = rv1;
  assign bus.busy_o        = busy;
  assign bus.resp_data_o   = res_q;
  assign bus.resp_zero_o   = zero_q;
  assign bus.alu_data1_o   = d1_q;
  assign bus.alu_data2_o   = d2_q;
  assign bus.alu_opcode_o  = op_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LAT, default 1, ALU settle cycles before result capture; legal range 1..8.
REQ-002 clk_i  in  1  single clock; all state changes on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 reqN_valid_i  in  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready_o  out  1  arbiter accepts requester N this cycle.
REQ-006 reqN_data1_i  in  32  operand 1 from requester N.
REQ-007 reqN_data2_i  in  32  operand 2 from requester N.
REQ-008 reqN_opcode_i  in  3  ALU opcode from requester N, passed through unmodified.
REQ-009 respN_valid_o  out  1  result for requester N available.
REQ-010 respN_ready_i  in  1  requester N consumes result.
REQ-011 resp_data_o  out  32  captured ALU result, shared by both response ports.
REQ-012 resp_zero_o  out  1  captured ALU zero flag.
REQ-013 alu_data1_o / alu_data2_o  out  32 each  operands to shared ALU.
REQ-014 alu_opcode_o  out  3  opcode to shared ALU.
REQ-015 alu_data_i  in  32; alu_zero_i  in  1  ALU result and zero flag.
REQ-016 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, EXEC, RESP; one operation in flight at most.
REQ-018 IDLE grant: one valid -> that requester; both valid -> requester not served last (round-robin, see REQ-032).
REQ-019 reqN_ready_o = (state==IDLE) && grant==N; at most one ready high; handshake = valid && ready.
REQ-020 On handshake: latch data1, data2, opcode, grant index; load counter with ALU_LAT-1; go EXEC.
REQ-021 alu_data1_o/alu_data2_o/alu_opcode_o driven from latched registers; stable throughout EXEC and RESP.
REQ-022 EXEC: counter decrements each cycle; in cycle with counter==0 capture alu_data_i/alu_zero_i into resp_data_o/resp_zero_o and go RESP.
REQ-023 Latency: respN_valid_o rises ALU_LAT+1 cycles after the accept cycle.
REQ-024 RESP: respG_valid_o high for granted G only; resp_data_o/resp_zero_o held stable until respG_ready_i.
REQ-025 On response handshake: go IDLE, update last-served pointer to G; no request accepted in the same cycle.
REQ-026 Minimum issue interval ALU_LAT+2 cycles per operation.
REQ-027 Valid withdrawn in IDLE before handshake: no state change, no error.
REQ-028 respN_ready_i ignored when respN_valid_o low; reqN_* ignored outside IDLE.
REQ-029 Opcode treated opaque (incl. 3'b110); arbiter never alters operands or opcode.

Reset
REQ-030 While rst_i high: state IDLE, all reqN_ready_o 0, respN_valid_o 0, resp_data_o 0, resp_zero_o 0, alu_* outputs 0, counter 0, busy_o 0.
REQ-031 Reset mid-operation (EXEC or RESP) discards the operation; no response issued; last-served pointer reset to 1 (requester 0 wins first tie).

Configuration
REQ-032 Macro ALU_ARB_ROUND_ROBIN_EN: defined -> tie resolved per REQ-018 round-robin; undefined -> fixed priority, requester 0 always wins ties, pointer logic removed.

Verification
REQ-033 ALU_LAT=1, req0 add 5,7 op 000, resp0_ready_i=1 -> resp0_valid_o 2 cycles after accept, resp_data_o=12, resp_zero_o=0, resp1_valid_o never high.
REQ-034 Both valid from reset, macro defined -> req0 served, then req1, then req0; macro undefined with req0 held valid -> req1 never accepted.
REQ-035 resp0_ready_i low 5 cycles -> resp0_valid_o, resp_data_o stable, both reqN_ready_o 0, busy_o 1 throughout.
REQ-036 req1 sub 9,9 op 010 -> resp_data_o=0, resp_zero_o=1 on resp1.
REQ-037 rst_i pulsed during EXEC -> next cycle all outputs at reset values, no response for discarded op.
REQ-038 ALU_LAT=4, req0 op 001 data 1,3 -> alu_* stable 4 EXEC cycles, resp0_valid_o 5 cycles after accept, resp_data_o=8.
